// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a 1-cycle synchronous imem and
// queues {pc, instr} pairs in a prefetch FIFO for decode. Redirects flush everything queued.
module fetch_unit #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = 'h8000_0000,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
    logic [31:0]      instr_mem [FIFO_DEPTH];

    logic room;
    logic issue;
    logic push;
    logic pop;

    // Conservative credit: an outstanding read already owns a slot, a same-cycle pop earns nothing.
    assign room  = ({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C;
    assign issue = ~rst & ~redirect_valid & room;

    // A response landing in a reset or redirect cycle belongs to the abandoned stream.
    assign push  = inflight & ~rst & ~redirect_valid;

    assign out_valid  = (count != '0) & ~redirect_valid & ~rst;
    assign pop        = out_valid & out_ready;

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;
    assign out_instr  = instr_mem[rd_ptr];
    assign out_pc     = pc_mem[rd_ptr];
    assign fifo_count = count;

    // Control state: fetch PC, read tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Datapath: issue-time address capture and FIFO storage, no reset needed.
    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc <= fetch_pc;
        end
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/flush scenarios plus a randomized run scored
// against a PC-stream and occupancy model derived from the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] RPC     = 32'h8000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] salt;

    function automatic logic [31:0] instr_of(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    // Default instance (depth 4, RESET_PC 0x80000000)
    logic        rst, imem_req, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    logic [2:0]  fifo_count;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fifo_count(fifo_count)
    );
    always @(posedge clk) imem_rdata <= instr_of(imem_addr, salt);

    // Depth-2 instance
    logic        d2_rst, d2_req, d2_rv, d2_valid, d2_ready;
    logic [31:0] d2_addr, d2_rdata, d2_rpc, d2_instr, d2_pc;
    logic [1:0]  d2_count;

    fetch_unit #(.FIFO_DEPTH(2)) u_d2 (
        .clk(clk), .rst(d2_rst), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_rdata(d2_rdata), .redirect_valid(d2_rv), .redirect_pc(d2_rpc),
        .out_valid(d2_valid), .out_ready(d2_ready), .out_instr(d2_instr),
        .out_pc(d2_pc), .fifo_count(d2_count)
    );
    always @(posedge clk) d2_rdata <= instr_of(d2_addr, salt);

    // Wrap-around instance
    logic        w_rst, w_req, w_rv, w_valid, w_ready;
    logic [31:0] w_addr, w_rdata, w_rpc, w_instr, w_pc;
    logic [2:0]  w_count;

    fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect_valid(w_rv), .redirect_pc(w_rpc),
        .out_valid(w_valid), .out_ready(w_ready), .out_instr(w_instr),
        .out_pc(w_pc), .fifo_count(w_count)
    );
    always @(posedge clk) w_rdata <= instr_of(w_addr, salt);

    // Leaves the caller at the negedge of cycle 0 (rst just released, inputs driven).
    task automatic reset_main(input logic rdy);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            redirect_pc = $urandom;
            #1;
            n_checks++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet: imem_req=%b out_valid=%b, required 0 and 0", imem_req, out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0; redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: fifo_count=%0d out_valid=%b, required 0 and 0", fifo_count, out_valid);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1 and %h", imem_req, imem_addr, RPC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr, exp_pc;
        reset_main(1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_addr = RPC + 32'(4 * c);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL stream_req c%0d: req=%b addr=%h, required 1 and %h", c, imem_req, imem_addr, exp_addr);
            end
            n_checks++;
            if (out_valid !== (c >= 2)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: out_valid=%b, required %b", c, out_valid, c >= 2);
            end
            if (c >= 2) begin
                exp_pc = RPC + 32'(4 * (c - 2));
                n_checks++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc, salt) || fifo_count !== 3'd1) begin
                    n_fail++;
                    $display("FAIL stream_head c%0d: pc=%h instr=%h count=%0d, required %h %h 1",
                             c, out_pc, out_instr, fifo_count, exp_pc, instr_of(exp_pc, salt));
                end
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_iss, exp_pop;
        int exp_cnt, pops;
        reset_main(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_cnt = (c < 1) ? 0 : ((c - 1 > 4) ? 4 : c - 1);
            n_checks++;
            if (imem_req !== (c <= 3) || (c <= 3 && imem_addr !== RPC + 32'(4 * c))) begin
                n_fail++;
                $display("FAIL full_req c%0d: req=%b addr=%h, required %b %h", c, imem_req, imem_addr, c <= 3, RPC + 32'(4 * c));
            end
            n_checks++;
            if (fifo_count !== 3'(exp_cnt) || out_valid !== (c >= 2)) begin
                n_fail++;
                $display("FAIL full_count c%0d: count=%0d valid=%b, required %0d %b", c, fifo_count, out_valid, exp_cnt, c >= 2);
            end
            if (c >= 2) begin
                n_checks++;
                if (out_pc !== RPC) begin
                    n_fail++;
                    $display("FAIL full_head c%0d: pc=%h, required %h", c, out_pc, RPC);
                end
            end
        end
        exp_iss = RPC + 32'd16;
        exp_pop = RPC;
        pops = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (k < 2) begin
                n_checks++;
                if (imem_req !== (k == 1)) begin
                    n_fail++;
                    $display("FAIL full_resume k%0d: req=%b, required %b", k, imem_req, k == 1);
                end
            end
            if (imem_req === 1'b1) begin
                n_checks++;
                if (imem_addr !== exp_iss) begin
                    n_fail++;
                    $display("FAIL full_issue_addr k%0d: addr=%h, required %h", k, imem_addr, exp_iss);
                end
                exp_iss += 32'd4;
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_pc !== exp_pop || out_instr !== instr_of(exp_pop, salt)) begin
                    n_fail++;
                    $display("FAIL full_drain k%0d: pc=%h instr=%h, required %h %h", k, out_pc, out_instr, exp_pop, instr_of(exp_pop, salt));
                end
                exp_pop += 32'd4;
                pops++;
            end
        end
        n_checks++;
        if (pops != 16) begin
            n_fail++;
            $display("FAIL full_drain_rate: pops=%0d, required 16", pops);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect(input logic [31:0] tgt);
        logic [31:0] exp_pc;
        exp_pc = {tgt[31:2], 2'b00};
        reset_main(1'b1);
        for (int i = 0; i < int'($urandom_range(3, 7)); i++) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = tgt;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle_n: req=%b valid=%b, required 0 0", imem_req, out_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_n1: req=%b addr=%h valid=%b, required 1 %h 0", imem_req, imem_addr, out_valid, exp_pc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_stale_n2: valid=%b pc=%h, required valid 0", out_valid, out_pc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc + 32'(4 * i) || out_instr !== instr_of(exp_pc + 32'(4 * i), salt)) begin
                n_fail++;
                $display("FAIL redir_stream n%0d: valid=%b pc=%h, required 1 %h", i + 3, out_valid, out_pc, exp_pc + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp_pc;
        a = $urandom; b = $urandom;
        exp_pc = {b[31:2], 2'b00};
        reset_main(1'b1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = a;
        @(negedge clk);
        redirect_pc = b;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: req=%b valid=%b, required 0 0", imem_req, out_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL b2b_target: req=%b addr=%h, required 1 %h", imem_req, imem_addr, exp_pc);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL b2b_head: valid=%b pc=%h, required 1 %h", out_valid, out_pc, exp_pc);
        end
    endtask

    task automatic test_random();
        int occ, pv;
        logic prev_req, redir, req_exp, vld_exp;
        logic [31:0] exp_iss, exp_pop, tgt;
        reset_main(1'b1);
        occ = 0; prev_req = 1'b0; exp_iss = RPC; exp_pop = RPC;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            redir = (c > 2) && ($urandom_range(0, 24) == 0);
            tgt = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = redir; redirect_pc = tgt;
            #1;
            pv = prev_req ? 1 : 0;
            req_exp = !redir && (occ + pv < 4);
            vld_exp = !redir && (occ != 0);
            n_checks++;
            if (imem_req !== req_exp || (req_exp && imem_addr !== exp_iss)) begin
                n_fail++;
                $display("FAIL rand_req c%0d: req=%b addr=%h, required %b %h", c, imem_req, imem_addr, req_exp, exp_iss);
            end
            n_checks++;
            if (fifo_count !== 3'(occ) || out_valid !== vld_exp) begin
                n_fail++;
                $display("FAIL rand_occ c%0d: count=%0d valid=%b, required %0d %b", c, fifo_count, out_valid, occ, vld_exp);
            end
            if (vld_exp && out_ready) begin
                n_checks++;
                if (out_pc !== exp_pop || out_instr !== instr_of(exp_pop, salt)) begin
                    n_fail++;
                    $display("FAIL rand_pop c%0d: pc=%h instr=%h, required %h %h", c, out_pc, out_instr, exp_pop, instr_of(exp_pop, salt));
                end
            end
            if (redir) begin
                occ = 0; prev_req = 1'b0;
                exp_iss = {tgt[31:2], 2'b00}; exp_pop = exp_iss;
            end else begin
                occ = occ + pv - ((vld_exp && out_ready) ? 1 : 0);
                if (req_exp) exp_iss += 32'd4;
                if (vld_exp && out_ready) exp_pop += 32'd4;
                prev_req = req_exp;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_inflight();
        bit found;
        reset_main(1'b0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (fifo_count === 3'd3) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_inflight_fill: count=%0d, required to reach 3 within 10 cycles", fifo_count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_inflight_hold: req=%b valid=%b, required 0 0", imem_req, out_valid);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL rst_inflight_after: count=%0d valid=%b req=%b addr=%h, required 0 0 1 %h",
                     fifo_count, out_valid, imem_req, imem_addr, RPC);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_inflight_stale: valid=%b pc=%h, required valid 0", out_valid, out_pc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== instr_of(RPC, salt)) begin
            n_fail++;
            $display("FAIL rst_inflight_head: valid=%b pc=%h, required 1 %h", out_valid, out_pc, RPC);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_depth2();
        int occ, pv;
        logic prev_req, req_exp, vld_exp;
        logic [31:0] exp_iss, exp_pop;
        @(negedge clk);
        d2_rst = 1'b1; d2_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        d2_rst = 1'b0;
        occ = 0; prev_req = 1'b0; exp_iss = RPC; exp_pop = RPC;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            d2_ready = (c < 6) ? 1'b0 : (c < 20 ? 1'b1 : ($urandom_range(0, 2) != 0));
            #1;
            pv = prev_req ? 1 : 0;
            req_exp = (occ + pv < 2);
            vld_exp = (occ != 0);
            n_checks++;
            if (d2_req !== req_exp || (req_exp && d2_addr !== exp_iss)) begin
                n_fail++;
                $display("FAIL d2_req c%0d: req=%b addr=%h, required %b %h", c, d2_req, d2_addr, req_exp, exp_iss);
            end
            n_checks++;
            if (d2_count !== 2'(occ) || d2_valid !== vld_exp) begin
                n_fail++;
                $display("FAIL d2_occ c%0d: count=%0d valid=%b, required %0d %b", c, d2_count, d2_valid, occ, vld_exp);
            end
            if (vld_exp && d2_ready) begin
                n_checks++;
                if (d2_pc !== exp_pop || d2_instr !== instr_of(exp_pop, salt)) begin
                    n_fail++;
                    $display("FAIL d2_pop c%0d: pc=%h instr=%h, required %h %h", c, d2_pc, d2_instr, exp_pop, instr_of(exp_pop, salt));
                end
                exp_pop += 32'd4;
            end
            occ = occ + pv - ((vld_exp && d2_ready) ? 1 : 0);
            if (req_exp) exp_iss += 32'd4;
            prev_req = req_exp;
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc;
        @(negedge clk);
        w_rst = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        w_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if (w_req !== 1'b1 || w_addr !== WRAP_PC + 32'(4 * c)) begin
                n_fail++;
                $display("FAIL wrap_req c%0d: req=%b addr=%h, required 1 %h", c, w_req, w_addr, WRAP_PC + 32'(4 * c));
            end
            if (c >= 2) begin
                exp_pc = WRAP_PC + 32'(4 * (c - 2));
                n_checks++;
                if (w_valid !== 1'b1 || w_pc !== exp_pc || w_instr !== instr_of(exp_pc, salt) || w_count !== 3'd1) begin
                    n_fail++;
                    $display("FAIL wrap_head c%0d: valid=%b pc=%h count=%0d, required 1 %h 1", c, w_valid, w_pc, w_count, exp_pc);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        salt = $urandom;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        d2_rst = 1'b1; d2_rv = 1'b0; d2_rpc = '0; d2_ready = 1'b0;
        w_rst = 1'b1; w_rv = 1'b0; w_rpc = '0; w_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect(32'h8000_0100);
        test_redirect(32'h8000_0203);
        test_redirect($urandom);
        test_back_to_back();
        test_random();
        test_reset_inflight();
        test_depth2();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
